lin_frame_rx: RTL and testbench

Serial LIN frame receiver for the responder/monitor end of the bus. It samples the single-wire line driven by the commander header and responder transmitters, and detects the break. It checks the sync field, decodes and parity-checks the protected identifier, and deserialises 8 data bytes plus a classic checksum. Validated PID and data are presented as parallel words with one-cycle status pulses; this is the inverse of the header/response serialisers in the top level.

---
 rtl/lin_pkg.sv | 19 +
 rtl/lin_uart_rx_byte.sv | 46 ++++
 rtl/lin_frame_rx.sv | 130 +++++++++++++
 tb/tb_lin_frame_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lin_pkg.sv
// lin_pkg: shared LIN receiver types, sync byte constant, PID parity and classic checksum helpers
package lin_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_DELIM,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CHK
  } lin_rx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h55;
  function automatic logic [1:0] lin_pid_parity(input logic [5:0] id);
    return {~(id[1] ^ id[3] ^ id[4] ^ id[5]), id[0] ^ id[1] ^ id[2] ^ id[4]};
  endfunction
  function automatic logic [8:0] lin_cks_add(input logic [8:0] sum, input logic [7:0] b);
    return {1'b0, sum[7:0]} + {1'b0, b} + {8'd0, sum[8]};
  endfunction
endpackage

// File: rtl/lin_uart_rx_byte.sv
// lin_uart_rx_byte: start/8 data/stop sampler; in sys_clk rst start_en sdi_sync, out rx_byte byte_valid stop_err bit_cnt (0 = waiting for start edge)
module lin_uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start_en,
  input  logic       sdi_sync,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err,
  output logic [3:0] bit_cnt
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  logic prev, tick, at_stop;
  assign tick = bit_cnt != 4'd0 && cnt == '0;
  assign at_stop = tick && bit_cnt == 4'd10;
  assign byte_valid = at_stop && sdi_sync;
  assign stop_err = at_stop && !sdi_sync;
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prev <= 1'b1;
      rx_byte <= '0;
      bit_cnt <= '0;
      cnt <= '0;
    end else begin
      prev <= sdi_sync;
      if (!start_en) begin
        bit_cnt <= '0;
        cnt <= '0;
      end else if (bit_cnt == 4'd0) begin
        if (prev && !sdi_sync) begin
          bit_cnt <= 4'd1;
          cnt <= CW'(CLKS_PER_BIT / 2 - 1);
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt <= CW'(CLKS_PER_BIT - 1);
        bit_cnt <= (bit_cnt == 4'd10 || (bit_cnt == 4'd1 && sdi_sync)) ? 4'd0 : bit_cnt + 4'd1;
        if (bit_cnt >= 4'd2 && bit_cnt <= 4'd9) rx_byte <= {sdi_sync, rx_byte[7:1]};
      end
    end
  end
endmodule

// File: rtl/lin_frame_rx.sv
// lin_frame_rx: LIN frame receiver; in sys_clk rst sdi, out pid data checksum, pulses hdr_valid frame_valid sync_err parity_err chk_err frame_err timeout_err, busy
module lin_frame_rx
  import lin_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int BREAK_BITS   = 13,
  parameter int TIMEOUT_BITS = 14
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        sdi,
  output logic [5:0]  pid,
  output logic [63:0] data,
  output logic [7:0]  checksum,
  output logic        hdr_valid,
  output logic        frame_valid,
  output logic        busy,
  output logic        sync_err,
  output logic        parity_err,
  output logic        chk_err,
  output logic        frame_err,
  output logic        timeout_err
);
  localparam int BRK_TH = BREAK_BITS * CLKS_PER_BIT;
  localparam int TO_TH = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int BW = $clog2(BRK_TH + 1);
  localparam int TW = $clog2(TO_TH + 1);
  lin_rx_state_t state;
  logic sdi_meta, sdi_sync, sdi_prev;
  logic [BW-1:0] brk_cnt;
  logic [TW-1:0] to_cnt;
  logic [8:0] acc;
  logic [2:0] idx;
  logic [5:0] pid_sh;
  logic [63:0] data_sh;
  logic [7:0] rx_byte;
  logic [3:0] rx_bit;
  logic byte_valid, stop_err, fall, in_frame, start_en, to_run, brk_hit, to_hit;
  assign fall = sdi_prev & ~sdi_sync;
  assign in_frame = state inside {S_SYNC, S_PID, S_DATA, S_CHK};
  assign start_en = in_frame || state == S_DELIM;
  assign to_run = start_en && rx_bit == 4'd0 && !fall;
  assign brk_hit = !sdi_sync && brk_cnt == BW'(BRK_TH - 1) && state != S_BREAK;
  assign to_hit = to_run && to_cnt == TW'(TO_TH - 1);
  assign busy = state != S_IDLE;
  lin_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start_en  (start_en),
    .sdi_sync  (sdi_sync),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .stop_err  (stop_err),
    .bit_cnt   (rx_bit)
  );
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= S_IDLE;
      sdi_meta <= 1'b1;
      sdi_sync <= 1'b1;
      sdi_prev <= 1'b1;
      brk_cnt <= '0;
      to_cnt <= '0;
      acc <= '0;
      idx <= '0;
      pid_sh <= '0;
      data_sh <= '0;
      pid <= '0;
      data <= '0;
      checksum <= '0;
      {hdr_valid, frame_valid, sync_err, parity_err, chk_err, frame_err, timeout_err} <= '0;
    end else begin
      sdi_meta <= sdi;
      sdi_sync <= sdi_meta;
      sdi_prev <= sdi_sync;
      brk_cnt <= sdi_sync ? '0 : brk_cnt + BW'(brk_cnt != BW'(BRK_TH));
      to_cnt <= to_run ? to_cnt + TW'(1) : '0;
      {hdr_valid, frame_valid, sync_err, parity_err, chk_err, frame_err, timeout_err} <= '0;
      if (brk_hit) begin
        frame_err <= in_frame;
        state <= S_BREAK;
      end else if (to_hit) begin
        timeout_err <= 1'b1;
        state <= S_IDLE;
      end else if (stop_err) begin
        frame_err <= 1'b1;
        state <= S_IDLE;
      end else begin
        case (state)
          S_BREAK: if (sdi_sync) state <= S_DELIM;
          S_DELIM: if (fall) state <= S_SYNC;
          S_SYNC: if (byte_valid) begin
            sync_err <= rx_byte != SYNC_BYTE;
            state <= rx_byte == SYNC_BYTE ? S_PID : S_IDLE;
          end
          S_PID: if (byte_valid) begin
            if (lin_pid_parity(rx_byte[5:0]) == rx_byte[7:6]) begin
              hdr_valid <= 1'b1;
              pid_sh <= rx_byte[5:0];
              acc <= '0;
              idx <= '0;
              state <= S_DATA;
            end else begin
              parity_err <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_DATA: if (byte_valid) begin
            data_sh[{idx, 3'd0} +: 8] <= rx_byte;
            acc <= lin_cks_add(acc, rx_byte);
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= S_CHK;
          end
          S_CHK: if (byte_valid) begin
            if (rx_byte == ~acc[7:0]) begin
              pid <= pid_sh;
              data <= data_sh;
              checksum <= rx_byte;
              frame_valid <= 1'b1;
            end else begin
              chk_err <= 1'b1;
            end
            state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lin_frame_rx.sv
// tb_lin_frame_rx: table-driven frames plus corner sequences, scoreboarded against lin_frame_rx status pulses
module tb_lin_frame_rx;
  localparam int CPB = 16;
  typedef enum int {EV_NONE, EV_HDR, EV_FRAME, EV_SYNC, EV_PAR, EV_CHK, EV_FERR, EV_TO} ev_t;
  typedef struct {
    ev_t         kind;
    logic [5:0]  pid;
    logic [63:0] data;
    logic [7:0]  cks;
  } exp_t;
  typedef struct {
    logic [7:0]  sync_b;
    logic [7:0]  pid_b;
    logic [63:0] d;
    logic [7:0]  cks;
    ev_t         ev1;
    ev_t         ev2;
    logic [5:0]  exp_pid;
    logic [63:0] exp_data;
    logic [7:0]  exp_cks;
  } vec_t;
  logic sys_clk = 1'b0, rst, sdi;
  logic [5:0] pid;
  logic [63:0] data;
  logic [7:0] checksum;
  logic hdr_valid, frame_valid, busy, sync_err, parity_err, chk_err, frame_err, timeout_err;
  int checks = 0, failures = 0, cyc = 0, hdr_cyc = 0, pid_start = 0, n;
  exp_t sb[$];
  exp_t e;
  ev_t got;
  vec_t vecs[6];
  lin_frame_rx #(.CLKS_PER_BIT(CPB), .BREAK_BITS(13), .TIMEOUT_BITS(14)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .sdi        (sdi),
    .pid        (pid),
    .data       (data),
    .checksum   (checksum),
    .hdr_valid  (hdr_valid),
    .frame_valid(frame_valid),
    .busy       (busy),
    .sync_err   (sync_err),
    .parity_err (parity_err),
    .chk_err    (chk_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    if (rst === 1'b0) begin
      n = int'(hdr_valid) + int'(frame_valid) + int'(sync_err) + int'(parity_err) + int'(chk_err) + int'(frame_err) + int'(timeout_err);
      got = hdr_valid ? EV_HDR : frame_valid ? EV_FRAME : sync_err ? EV_SYNC : parity_err ? EV_PAR :
            chk_err ? EV_CHK : frame_err ? EV_FERR : timeout_err ? EV_TO : EV_NONE;
      if (n != 0) begin
        checks++;
        if (got == EV_HDR) hdr_cyc = cyc;
        if (n > 1) begin
          failures++;
          $display("FAIL pulse_overlap count=%0d required=1", n);
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got=%0d required=none", got);
        end else begin
          e = sb.pop_front();
          if (got != e.kind) begin
            failures++;
            $display("FAIL event_kind got=%0d required=%0d", got, e.kind);
          end else if (got == EV_FRAME && {pid, data, checksum} !== {e.pid, e.data, e.cks}) begin
            failures++;
            $display("FAIL frame_outputs got=%h/%h/%h required=%h/%h/%h", pid, data, checksum, e.pid, e.data, e.cks);
          end
        end
      end
    end
  end
  task automatic check(input string name, input logic [127:0] got_v, input logic [127:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got_v, exp_v);
    end
  endtask
  task automatic expect_ev(input ev_t k, input logic [5:0] p, input logic [63:0] d, input logic [7:0] c);
    exp_t x;
    x.kind = k;
    x.pid = p;
    x.data = d;
    x.cks = c;
    if (k != EV_NONE) sb.push_back(x);
  endtask
  task automatic send_bit(input logic b);
    sdi = b;
    repeat (CPB) @(negedge sys_clk);
  endtask
  task automatic send_low(input int bits);
    sdi = 1'b0;
    repeat (bits * CPB) @(negedge sys_clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(b[k]);
    send_bit(1'b1);
  endtask
  task automatic send_header(input bit brk, input logic [7:0] s, input logic [7:0] p);
    if (brk) begin
      send_low(13);
      send_bit(1'b1);
    end
    send_byte(s);
    pid_start = cyc;
    send_byte(p);
  endtask
  task automatic send_frame(input bit brk, input logic [7:0] s, input logic [7:0] p, input logic [63:0] d, input logic [7:0] c);
    send_header(brk, s, p);
    for (int k = 0; k < 8; k++) send_byte(d[8*k +: 8]);
    send_byte(c);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask
  task automatic check_outputs(input string name, input logic [5:0] p, input logic [63:0] d, input logic [7:0] c);
    check(name, {pid, data, checksum}, {p, d, c});
  endtask
  initial begin
    vecs[0] = '{8'h55, 8'hAD, 64'h7F7F, 8'h01, EV_HDR, EV_FRAME, 6'h2D, 64'h7F7F, 8'h01};
    vecs[1] = '{8'h55, 8'hAD, 64'h7F7F, 8'h02, EV_HDR, EV_CHK, 6'h2D, 64'h7F7F, 8'h01};
    vecs[2] = '{8'h55, 8'h2D, 64'h7F7F, 8'h01, EV_PAR, EV_NONE, 6'h2D, 64'h7F7F, 8'h01};
    vecs[3] = '{8'h54, 8'hAD, 64'h7F7F, 8'h01, EV_SYNC, EV_NONE, 6'h2D, 64'h7F7F, 8'h01};
    vecs[4] = '{8'h55, 8'h50, 64'h0807060504030201, 8'hDB, EV_HDR, EV_FRAME, 6'h10, 64'h0807060504030201, 8'hDB};
    vecs[5] = '{8'h55, 8'h3C, 64'h1FFFF, 8'hFE, EV_HDR, EV_FRAME, 6'h3C, 64'h1FFFF, 8'hFE};
    rst = 1'b1;
    sdi = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    check("reset_outputs", {pid, data, checksum, busy, hdr_valid, frame_valid, sync_err, parity_err, chk_err, frame_err, timeout_err}, '0);
    send_bit(1'b1);
    for (int i = 0; i < 6; i++) begin
      expect_ev(vecs[i].ev1, vecs[i].exp_pid, vecs[i].exp_data, vecs[i].exp_cks);
      expect_ev(vecs[i].ev2, vecs[i].exp_pid, vecs[i].exp_data, vecs[i].exp_cks);
      send_frame(1'b1, vecs[i].sync_b, vecs[i].pid_b, vecs[i].d, vecs[i].cks);
      check($sformatf("vec%0d_events_done", i), sb.size(), 0);
      check($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
      check_outputs($sformatf("vec%0d_outputs", i), vecs[i].exp_pid, vecs[i].exp_data, vecs[i].exp_cks);
      if (vecs[i].ev1 == EV_HDR) check($sformatf("vec%0d_hdr_latency", i), hdr_cyc - pid_start, 155);
    end
    send_low(12);
    check("short_low_busy", busy, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("short_low_events", sb.size(), 0);
    check_outputs("short_low_outputs", 6'h3C, 64'h1FFFF, 8'hFE);
    expect_ev(EV_HDR, '0, '0, '0);
    expect_ev(EV_FERR, '0, '0, '0);
    expect_ev(EV_HDR, '0, '0, '0);
    expect_ev(EV_FRAME, 6'h2D, 64'h7F7F, 8'h01);
    send_header(1'b1, 8'h55, 8'hAD);
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_byte(8'h00);
    send_low(14);
    send_bit(1'b1);
    send_frame(1'b0, 8'h55, 8'hAD, 64'h7F7F, 8'h01);
    check("break_mid_data_events", sb.size(), 0);
    check_outputs("break_mid_data_outputs", 6'h2D, 64'h7F7F, 8'h01);
    expect_ev(EV_HDR, '0, '0, '0);
    expect_ev(EV_TO, '0, '0, '0);
    send_header(1'b1, 8'h55, 8'hAD);
    repeat (15) send_bit(1'b1);
    check("timeout_events", sb.size(), 0);
    check("timeout_busy", busy, 1'b0);
    expect_ev(EV_HDR, '0, '0, '0);
    send_header(1'b1, 8'h55, 8'hAD);
    send_byte(8'h7F);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_data_outputs", {pid, data, checksum, busy, hdr_valid, frame_valid, sync_err, parity_err, chk_err, frame_err, timeout_err}, '0);
    rst = 1'b0;
    sdi = 1'b1;
    send_bit(1'b1);
    check("rst_events", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
